// File: rtl/mem_pkg.sv
// Shared MEM-stage definitions: SRAM controller state encoding
// and default bus geometry.
package mem_pkg;

  localparam int DEF_WORD_WIDTH      = 32;
  localparam int DEF_DQ_WIDTH        = 16;
  localparam int DEF_SRAM_ADDR_WIDTH = 18;
  localparam int DEF_ADDR_BASE       = 1024;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

endpackage

// File: rtl/sram_beat_timer.sv
// Wait-state and beat counters for one multi-beat SRAM access.
// Counters sit at zero whenever run is low.
module sram_beat_timer #(
  parameter int BEATS       = 2,
  parameter int WAIT_CYCLES = 2,
  parameter int BW          = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  output logic [BW-1:0] beat,
  output logic          beat_done,
  output logic          last_beat
);

  localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [WW-1:0] wait_cnt;

  assign beat_done = run && (wait_cnt == WW'(WAIT_CYCLES - 1));
  assign last_beat = (beat == BW'(BEATS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      beat     <= '0;
    end else if (!run) begin
      wait_cnt <= '0;
      beat     <= '0;
    end else if (beat_done) begin
      wait_cnt <= '0;
      beat     <= last_beat ? '0 : beat + 1'b1;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sram_word_access_unit.sv
// MEM-stage SRAM controller: splits one CPU word access into
// BEATS narrow SRAM transfers and stalls the pipeline meanwhile.
module sram_word_access_unit
  import mem_pkg::*;
#(
  parameter int WORD_WIDTH      = DEF_WORD_WIDTH,
  parameter int DQ_WIDTH        = DEF_DQ_WIDTH,
  parameter int SRAM_ADDR_WIDTH = DEF_SRAM_ADDR_WIDTH,
  parameter int WAIT_CYCLES     = 2,
  parameter int ADDR_BASE       = DEF_ADDR_BASE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       read_en,
  input  logic                       write_en,
  input  logic [WORD_WIDTH-1:0]      address,
  input  logic [WORD_WIDTH-1:0]      write_data,
  input  logic                       wb_en_in,
  output logic [WORD_WIDTH-1:0]      read_data,
  output logic                       ready,
  output logic                       freeze,
  output logic                       wb_en_out,
  output logic [SRAM_ADDR_WIDTH-1:0] SRAM_ADDR,
  inout  wire  [DQ_WIDTH-1:0]        SRAM_DQ,
  output logic                       SRAM_WE_N,
  output logic                       SRAM_OE_N,
  output logic                       SRAM_CE_N,
  output logic                       SRAM_UB_N,
  output logic                       SRAM_LB_N
);

  localparam int BEATS = WORD_WIDTH / DQ_WIDTH;
  localparam int SHIFT = $clog2(WORD_WIDTH / 8);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [1:0]                 state;
  logic                       op_wr;
  logic [WORD_WIDTH-1:0]      wdata_q;
  logic [SRAM_ADDR_WIDTH-1:0] base_q;
  logic [BW-1:0]              beat;
  logic                       beat_done;
  logic                       last_beat;
  logic                       in_acc;
  logic                       req;
  logic [WORD_WIDTH-1:0]      word_idx;
  logic [WORD_WIDTH-1:0]      word_off;
  logic [DQ_WIDTH-1:0]        dq_out;

  assign req      = read_en | write_en;
  assign in_acc   = (state == S_ACCESS);
  assign word_idx = (address - WORD_WIDTH'(ADDR_BASE)) >> SHIFT;
  assign word_off = word_idx * WORD_WIDTH'(BEATS);

  sram_beat_timer #(
    .BEATS       (BEATS),
    .WAIT_CYCLES (WAIT_CYCLES),
    .BW          (BW)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .run       (in_acc),
    .beat      (beat),
    .beat_done (beat_done),
    .last_beat (last_beat)
  );

  always_comb begin
    dq_out = '0;
    for (int b = 0; b < BEATS; b++)
      if (beat == BW'(b))
        dq_out = wdata_q[b*DQ_WIDTH +: DQ_WIDTH];
  end

  assign SRAM_DQ   = (in_acc && op_wr) ? dq_out : 'z;
  assign SRAM_ADDR = in_acc ? base_q + SRAM_ADDR_WIDTH'(beat) : '0;
  assign SRAM_CE_N = ~in_acc;
  assign SRAM_UB_N = ~in_acc;
  assign SRAM_LB_N = ~in_acc;
  assign SRAM_WE_N = ~(in_acc & op_wr);
  assign SRAM_OE_N = ~(in_acc & ~op_wr);

  assign ready     = (state == S_DONE) | ((state == S_IDLE) & ~req);
  assign freeze    = ~ready;
  assign wb_en_out = wb_en_in & ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      op_wr     <= 1'b0;
      wdata_q   <= '0;
      base_q    <= '0;
      read_data <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req) begin
            state   <= S_ACCESS;
            op_wr   <= write_en;
            wdata_q <= write_data;
            base_q  <= SRAM_ADDR_WIDTH'(word_off);
          end
        end
        S_ACCESS: begin
          if (beat_done && !op_wr)
            for (int b = 0; b < BEATS; b++)
              if (beat == BW'(b))
                read_data[b*DQ_WIDTH +: DQ_WIDTH] <= SRAM_DQ;
          if (beat_done && last_beat)
            state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
